// File: rtl/cl2st_beforeafu_if.sv
`default_nettype none
// ============================================================================
// Module      : cl2st_beforeafu_if
// Description : Bus bundle for the CL-to-ST unpacker. It carries the
//               show-ahead FIFO read side (ff_empty, ff_q, ff_rdreq), the
//               Avalon-ST source towards the AFU (source_*) and the error
//               strobes.
//               master : unpacker view (pops the FIFO, drives the stream)
//               slave  : environment view (FIFO + AFU sink)
// Revision    : 1.0  initial release
// ============================================================================
interface cl2st_beforeafu_if #(
    parameter int CL  = 512,
    parameter int ST2 = 8
);
    logic           ff_empty;
    logic [CL-1:0]  ff_q;
    logic           ff_rdreq;
    logic           source_ready;
    logic           source_valid;
    logic [ST2-1:0] source_data;
    logic           source_sop;
    logic           source_eop;
    logic           err_len;
    logic           err_seq;

    modport master (
        input  ff_empty, ff_q, source_ready,
        output ff_rdreq, source_valid, source_data, source_sop, source_eop,
               err_len, err_seq
    );

    modport slave (
        output ff_empty, ff_q, source_ready,
        input  ff_rdreq, source_valid, source_data, source_sop, source_eop,
               err_len, err_seq
    );
endinterface
`default_nettype wire

// File: rtl/cl2st_beforeafu.sv
`default_nettype none
// ============================================================================
// Module      : cl2st_beforeafu
// Description : Unpacks 512-bit cache lines from a show-ahead FIFO into an
//               ST2-bit Avalon-ST stream with sop/eop framing.
//               CL layout: head in the top CL_HEAD bits (bit 15 = first CL of
//               frame, bit 14 = last CL of frame, low W_LEN_CLHEAD bits =
//               number of STs); ST 0 sits at the MSB end of the payload.
// Ports       : clk          - clock
//               rst_n_sync   - synchronous reset, active low
//               bus (master) - ff_empty/ff_q/ff_rdreq FIFO side,
//                              source_ready/valid/data/sop/eop stream side,
//                              err_len/err_seq one-cycle error strobes
// Revision    : 1.0  initial release
// ============================================================================
module cl2st_beforeafu #(
    parameter int CL                  = 512,
    parameter int CL_HEAD             = 16,
    parameter int ST2                 = 8,
    parameter int MAX_NUM_OF_ST_IN_CL = 62,
    parameter int W_LEN_CLHEAD        = 10
) (
    input  wire logic           clk,
    input  wire logic           rst_n_sync,
    cl2st_beforeafu_if.master   bus
);

    localparam int c_CL_PAYLOAD = CL - CL_HEAD;
    localparam int c_FIRST_BIT  = CL - 1;
    localparam int c_LAST_BIT   = CL - 2;

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_EMIT = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic                    r_first;
    logic                    r_last;
    logic [W_LEN_CLHEAD-1:0] r_len;
    logic [c_CL_PAYLOAD-1:0] r_payload;
    logic [W_LEN_CLHEAD-1:0] r_idx;
    logic                    r_in_frame;
    logic                    r_err_len;
    logic                    r_err_seq;

    logic                    w_emit;
    logic                    w_last_idx;
    logic                    w_xfer;
    logic                    w_last_xfer;
    logic                    w_eop_xfer;
    logic                    w_load;
    logic [W_LEN_CLHEAD-1:0] w_new_len;
    logic                    w_new_first;
    logic                    w_in_frame_eff;
    logic                    w_len_bad;
    logic                    w_seq_drop;
    logic                    w_seq_restart;
    logic                    w_accept;
    logic                    w_unused_head;

    // Reserved head bits between the flags and the length field carry no meaning here.
    assign w_unused_head = ^bus.ff_q[CL-3 -: (CL_HEAD - 2 - W_LEN_CLHEAD)];

    assign w_emit      = (r_state == c_S_EMIT);
    assign w_last_idx  = (r_idx == (r_len - W_LEN_CLHEAD'(1)));
    assign w_xfer      = w_emit && bus.source_ready;
    assign w_last_xfer = w_xfer && w_last_idx;
    assign w_eop_xfer  = w_last_xfer && r_last;

    // A CL is popped when idle, or back-to-back on the final beat of the
    // current CL so that consecutive CLs stream without a bubble.
    assign w_load = rst_n_sync && !bus.ff_empty && (!w_emit || w_last_xfer);

    assign w_new_len   = bus.ff_q[c_CL_PAYLOAD +: W_LEN_CLHEAD];
    assign w_new_first = bus.ff_q[c_FIRST_BIT];

    // The eop beat closing the current frame happens in the same cycle as a
    // back-to-back load, so the load must already see the frame as closed.
    assign w_in_frame_eff = r_in_frame && !w_eop_xfer;

    assign w_len_bad     = (w_new_len == '0) ||
                           (w_new_len > W_LEN_CLHEAD'(MAX_NUM_OF_ST_IN_CL));
    assign w_seq_drop    = !w_new_first && !w_in_frame_eff;
    assign w_seq_restart =  w_new_first &&  w_in_frame_eff;
    assign w_accept      = w_load && !w_len_bad && !w_seq_drop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_S_EMIT;
                end
            end
            c_S_EMIT: begin
                if (w_last_xfer) begin
                    w_state_nxt = w_accept ? c_S_EMIT : c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.ff_rdreq     = w_load;
        bus.source_valid = w_emit;
        bus.source_data  = w_emit ? r_payload[c_CL_PAYLOAD-1 -: ST2] : '0;
        bus.source_sop   = w_emit && r_first && (r_idx == '0);
        bus.source_eop   = w_emit && r_last && w_last_idx;
        bus.err_len      = r_err_len;
        bus.err_seq      = r_err_seq;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_len      <= '0;
            r_payload  <= '0;
            r_idx      <= '0;
            r_in_frame <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_seq  <= 1'b0;
        end else begin
            r_err_len <= w_load && w_len_bad;
            r_err_seq <= w_load && !w_len_bad && (w_seq_drop || w_seq_restart);

            if (w_load) begin
                // Dropped CLs are latched too; the FSM simply never emits them.
                r_first   <= bus.ff_q[c_FIRST_BIT];
                r_last    <= bus.ff_q[c_LAST_BIT];
                r_len     <= w_new_len;
                r_payload <= bus.ff_q[c_CL_PAYLOAD-1:0];
                r_idx     <= '0;
            end else if (w_xfer) begin
                // Shift so the next ST is always at the MSB end.
                r_payload <= {r_payload[c_CL_PAYLOAD-ST2-1:0], {ST2{1'b0}}};
                r_idx     <= r_idx + W_LEN_CLHEAD'(1);
            end

            // A new first CL wins over the eop of the previous frame.
            if (w_accept && w_new_first) begin
                r_in_frame <= 1'b1;
            end else if (w_eop_xfer) begin
                r_in_frame <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cl2st_beforeafu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cl2st_beforeafu
// Description : Self-checking bench for cl2st_beforeafu. A FIFO model feeds
//               CLs; every pushed CL is expanded by a frame-level reference
//               model into expected beats / error events held in queues, and
//               a negedge monitor pops and compares them against the stream.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cl2st_beforeafu;

    localparam int CL    = 512;
    localparam int HEAD  = 16;
    localparam int ST2   = 8;
    localparam int PAY   = CL - HEAD;
    localparam int MAXST = 62;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n_sync;
    always #5 clk = ~clk;

    cl2st_beforeafu_if #(.CL(CL), .ST2(ST2)) bus ();

    cl2st_beforeafu #(
        .CL(CL), .CL_HEAD(HEAD), .ST2(ST2),
        .MAX_NUM_OF_ST_IN_CL(MAXST), .W_LEN_CLHEAD(10)
    ) dut (
        .clk(clk),
        .rst_n_sync(rst_n_sync),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [CL-1:0] fifo[$];
    beat_t         exp_q[$];
    int            err_q[$];   // 1 = length error, 2 = sequence error
    bit            model_in_frame = 1'b0;

    int cyc = 0, pops = 0, ready_mode = 3;
    bit pop_pending = 1'b0, load_seen = 1'b0;
    int load_cyc = 0, sop_cyc = 0, eop_cyc = 0;
    int beats_seen = 0, sop_count = 0, err_len_cnt = 0, err_seq_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CL-1:0] make_cl(input bit first, input bit last, input int len);
        logic [CL-1:0] w;
        for (int i = 0; i < CL / 32; i++) w[i*32 +: 32] = $urandom;
        w[CL-1] = first;
        w[CL-2] = last;
        w[PAY +: 10] = len[9:0];
        return w;
    endfunction

    // Reference model: frame rules applied CL by CL in FIFO order.
    task automatic push_cl(input logic [CL-1:0] w);
        bit first, last;
        int len;
        first = w[CL-1];
        last  = w[CL-2];
        len   = int'(w[PAY +: 10]);
        fifo.push_back(w);
        if (len == 0 || len > MAXST) begin
            err_q.push_back(1);
        end else if (!first && !model_in_frame) begin
            err_q.push_back(2);
        end else begin
            if (first && model_in_frame) err_q.push_back(2);
            if (first) model_in_frame = 1'b1;
            for (int k = 0; k < len; k++) begin
                beat_t b;
                b.d   = w[PAY-1-k*ST2 -: ST2];
                b.sop = first && (k == 0);
                b.eop = last && (k == len - 1);
                exp_q.push_back(b);
            end
            if (last) model_in_frame = 1'b0;
        end
    endtask

    // One clock: apply FIFO pop decided last cycle, then new inputs, then sample rdreq.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (pop_pending && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        case (ready_mode)
            0:       bus.source_ready = 1'b1;
            1:       bus.source_ready = ~bus.source_ready;
            2:       bus.source_ready = ($urandom % 4) != 0;
            default: bus.source_ready = 1'b0;
        endcase
        bus.ff_empty = (fifo.size() == 0);
        bus.ff_q     = (fifo.size() == 0) ? '0 : fifo[0];
        #1;
        pop_pending = bus.ff_rdreq;
        if (pop_pending) begin
            check("rdreq_while_empty", 64'(bus.ff_empty), 64'd0);
            if (!load_seen) begin
                load_seen = 1'b1;
                load_cyc  = cyc;
            end
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || fifo.size() != 0 || err_q.size() != 0) && n < max) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        check("drain_timeout", 64'(n < max), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.source_valid), 64'd0);
        check({tag, "_data"},  64'(bus.source_data),  64'd0);
        check({tag, "_sop"},   64'(bus.source_sop),   64'd0);
        check({tag, "_eop"},   64'(bus.source_eop),   64'd0);
        check({tag, "_rdreq"}, 64'(bus.ff_rdreq),     64'd0);
        check({tag, "_errl"},  64'(bus.err_len),      64'd0);
        check({tag, "_errs"},  64'(bus.err_seq),      64'd0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (rst_n_sync === 1'b1) begin
            if (bus.source_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {bus.source_data, bus.source_sop, bus.source_eop}, 64'h0);
                    if ({bus.source_data, bus.source_sop, bus.source_eop} == 10'h0) begin
                        n_bad++;
                        $display("FAIL unexpected_beat: got a beat, expected none");
                    end
                end else begin
                    check("beat", 64'({bus.source_data, bus.source_sop, bus.source_eop}), 64'(exp_q[0]));
                    if (bus.source_ready) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                        if (bus.source_sop) begin sop_cyc = cyc; sop_count++; end
                        if (bus.source_eop) eop_cyc = cyc;
                    end
                end
            end
            if (bus.err_len) begin
                err_len_cnt++;
                if (err_q.size() == 0) check("err_len_unexpected", 64'd1, 64'd0);
                else check("err_len_kind", 64'(err_q.pop_front()), 64'd1);
            end
            if (bus.err_seq) begin
                err_seq_cnt++;
                if (err_q.size() == 0) check("err_seq_unexpected", 64'd1, 64'd0);
                else check("err_seq_kind", 64'(err_q.pop_front()), 64'd2);
            end
        end
    end

    initial begin
        logic [CL-1:0] w;
        int p0, b0, s0, e0, n;

        rst_n_sync       = 1'b0;
        bus.ff_empty     = 1'b1;
        bus.ff_q         = '0;
        bus.source_ready = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        check_all_zero("reset");
        rst_n_sync = 1'b1;

        // Single CL, len 3, known data; latency and pop count.
        ready_mode = 0;
        load_seen  = 1'b0;
        p0 = pops;
        w = make_cl(1'b1, 1'b1, 3);
        w[PAY-1 -: 8] = 8'h01;
        w[PAY-9 -: 8] = 8'h02;
        w[PAY-17 -: 8] = 8'h03;
        push_cl(w);
        drain(50);
        check("t1_latency", 64'(sop_cyc - load_cyc), 64'd1);
        check("t1_span", 64'(eop_cyc - sop_cyc), 64'd2);
        check("t1_pops", 64'(pops - p0), 64'd1);

        // Two-CL frame, 62 + 5 STs, no bubble between CLs.
        push_cl(make_cl(1'b1, 1'b0, 62));
        push_cl(make_cl(1'b0, 1'b1, 5));
        drain(200);
        check("t2_span", 64'(eop_cyc - sop_cyc), 64'd66);

        // Ready toggling every cycle on a len 4 CL.
        ready_mode = 1;
        b0 = beats_seen;
        push_cl(make_cl(1'b1, 1'b1, 4));
        drain(50);
        check("t3_span", 64'(eop_cyc - sop_cyc), 64'd6);
        check("t3_beats", 64'(beats_seen - b0), 64'd4);

        // Length errors: 0 and 63.
        ready_mode = 0;
        p0 = pops; b0 = beats_seen; e0 = err_len_cnt;
        push_cl(make_cl(1'b1, 1'b1, 0));
        push_cl(make_cl(1'b1, 1'b1, 63));
        drain(50);
        check("t4_pops", 64'(pops - p0), 64'd2);
        check("t4_beats", 64'(beats_seen - b0), 64'd0);
        check("t4_errlen", 64'(err_len_cnt - e0), 64'd2);

        // Sequence errors: orphan CL, then a restart inside an open frame.
        e0 = err_seq_cnt; s0 = sop_count;
        push_cl(make_cl(1'b0, 1'b1, 4));
        push_cl(make_cl(1'b1, 1'b0, 3));
        push_cl(make_cl(1'b1, 1'b1, 2));
        drain(50);
        check("t5_errseq", 64'(err_seq_cnt - e0), 64'd2);
        check("t5_sops", 64'(sop_count - s0), 64'd2);

        // Reset in the middle of a len 10 CL.
        b0 = beats_seen;
        push_cl(make_cl(1'b1, 1'b1, 10));
        n = 0;
        while (beats_seen < b0 + 2 && n < 50) begin
            cycle();
            n++;
        end
        check("t6_reach_beat2", 64'(beats_seen - b0), 64'd2);
        rst_n_sync       = 1'b0;
        ready_mode       = 3;
        bus.source_ready = 1'b0;
        exp_q.delete();
        model_in_frame   = 1'b0;
        cycle();
        @(negedge clk);
        check_all_zero("t6_reset");
        rst_n_sync = 1'b1;
        ready_mode = 0;
        s0 = sop_count;
        push_cl(make_cl(1'b1, 1'b1, 5));
        drain(50);
        check("t6_sops", 64'(sop_count - s0), 64'd1);

        // Random CL mix against random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int len, sel;
            sel = $urandom % 10;
            if (sel == 0)      len = 0;
            else if (sel == 1) len = 63 + ($urandom % 961);
            else               len = 1 + ($urandom % MAXST);
            push_cl(make_cl(($urandom % 3) == 0, ($urandom % 3) == 0, len));
            repeat ($urandom % 20) cycle();
        end
        drain(8000);

        check("final_exp_empty", 64'(exp_q.size()), 64'd0);
        check("final_err_empty", 64'(err_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
